// File: rtl/cpu_wb_master_bridge_pkg.sv
// Shared types and constants for the CPU-to-Wishbone master bridge.
// The bus-hang timeout is enabled with the CPU_WB_TIMEOUT_EN macro.
package cpu_wb_master_bridge_pkg;

    localparam int unsigned CPU_WB_AW       = 32;
    localparam int unsigned CPU_WB_DW       = 32;
    localparam logic [31:0] CPU_WB_ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  CPU_WB_SEL_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } cpu_wb_state_e;

endpackage

// File: rtl/cpu_wb_master_bridge_if.sv
// CPU memory port and Wishbone m0 port, bundled.
// The master modport is the bridge's view; slave is the CPU/interconnect side.
interface cpu_wb_master_bridge_if
    import cpu_wb_master_bridge_pkg::*;
#(
    parameter int unsigned AW = CPU_WB_AW,
    parameter int unsigned DW = CPU_WB_DW
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_dat_i, wb_ack_i,
        output cpu_rdata, cpu_ready,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, wb_dat_i, wb_ack_i,
        input  cpu_rdata, cpu_ready,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/cpu_wb_master_bridge_timeout.sv
// Bus-hang counter: cleared while clr_i, counts while en_i, flags expiry.
// Only instantiated when CPU_WB_TIMEOUT_EN is defined.
module cpu_wb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CW-1:0] cnt_q;
    logic          hit_s;

    // The edge that would take the count to LIMIT is the expiry edge.
    assign hit_s     = (cnt_q == CW'(LIMIT - 1));
    assign expired_o = en_i & hit_s;

    // Count BUS cycles; saturate at expiry so a stuck enable never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !hit_s) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/cpu_wb_master_bridge.sv
// Turns one held CPU request into one Wishbone classic cycle on m0.
// Optional bus-hang abort: define CPU_WB_TIMEOUT_EN.
module cpu_wb_master_bridge
    import cpu_wb_master_bridge_pkg::*;
#(
    parameter int unsigned   AW             = CPU_WB_AW,
    parameter int unsigned   DW             = CPU_WB_DW,
    parameter int unsigned   TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0] ERR_DATA       = CPU_WB_ERR_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_wb_master_bridge_if.master bus,
    output logic                  bus_err
);
    cpu_wb_state_e state_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] rdata_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          stb_q;
    logic          cyc_q;
    logic          ready_q;
    logic          err_q;
    logic          timeout_hit_s;
    logic          unused_addr_s;

    assign unused_addr_s = ^bus.cpu_addr[1:0];

`ifdef CPU_WB_TIMEOUT_EN
    cpu_wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == IDLE),
        .en_i      (state_q == BUS),
        .expired_o (timeout_hit_s)
    );
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign timeout_hit_s    = 1'b0;
`endif

    // Bus-cycle FSM with all outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
            sel_q   <= 4'h0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        adr_q   <= {bus.cpu_addr[AW-1:2], 2'b00};
                        dat_q   <= bus.cpu_wdata;
                        we_q    <= bus.cpu_we;
                        sel_q   <= CPU_WB_SEL_WORD;
                        stb_q   <= 1'b1;
                        cyc_q   <= 1'b1;
                        state_q <= BUS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUS: begin
                    // A real ack beats an expiry on the same edge.
                    if (bus.wb_ack_i) begin
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        rdata_q <= we_q ? rdata_q : bus.wb_dat_i;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else if (timeout_hit_s) begin
                        stb_q   <= 1'b0;
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        rdata_q <= we_q ? rdata_q : ERR_DATA;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= BUS;
                    end
                end
                DONE: begin
                    if (!bus.cpu_req) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    stb_q   <= 1'b0;
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_ready = ready_q;
    assign bus_err       = err_q;

endmodule
